// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// req0 is the execute stage and req1 is the branch/address unit. A three-state
// FSM (IDLE -> EXEC -> RESP) registers the winning operands, lets the ALU
// settle for one cycle, captures result/branch and returns them on the
// owner's response channel.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 always
// wins a contest). Default build is round-robin between the two requesters.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [DATA_W-1:0] req0_op_a_i,
    input  logic [DATA_W-1:0] req0_op_b_i,
    input  logic [OPC_W-1:0]  req0_op_code_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req1_op_a_i,
    input  logic [DATA_W-1:0] req1_op_b_i,
    input  logic [OPC_W-1:0]  req1_op_code_i,
    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic [DATA_W-1:0] rsp0_result_o,
    output logic              rsp0_branch_o,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [DATA_W-1:0] rsp1_result_o,
    output logic              rsp1_branch_o,
    output logic [DATA_W-1:0] alu_op_a_o,
    output logic [DATA_W-1:0] alu_op_b_o,
    output logic [OPC_W-1:0]  alu_op_code_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_branch_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [OPC_W-1:0]  op_code;
    } alu_req_t;

    state_t                 r_state;
    logic                   r_owner;
    alu_req_t               r_alu;
    logic [1:0]             r_rsp_valid;
    logic [1:0][DATA_W-1:0] r_rsp_result;
    logic [1:0]             r_rsp_branch;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic                   r_last_grant;
`endif

    alu_req_t   w_req0;
    alu_req_t   w_req1;
    logic       w_idle;
    logic       w_grant0;
    logic       w_grant1;
    logic [1:0] w_rsp_ready;

    assign w_req0      = '{op_a: req0_op_a_i, op_b: req0_op_b_i, op_code: req0_op_code_i};
    assign w_req1      = '{op_a: req1_op_a_i, op_b: req1_op_b_i, op_code: req1_op_code_i};
    assign w_rsp_ready = {rsp1_ready_i, rsp0_ready_i};

    // Grant decision; readies are held low while reset is asserted so nothing
    // handshakes on the reset edge.
    always_comb begin
        w_idle = (r_state == S_IDLE) && rst_ni;
`ifdef ALU_ARB_FIXED_PRIO_EN
        w_grant0 = req0_valid_i;
        w_grant1 = req1_valid_i & ~req0_valid_i;
`else
        // last_grant resets to 1, so the first contest goes to req0.
        w_grant0 = req0_valid_i & (~req1_valid_i |  r_last_grant);
        w_grant1 = req1_valid_i & (~req0_valid_i | ~r_last_grant);
`endif
    end

    assign req0_ready_o  = w_idle & w_grant0;
    assign req1_ready_o  = w_idle & w_grant1;
    assign busy_o        = (r_state != S_IDLE);
    assign alu_op_a_o    = r_alu.op_a;
    assign alu_op_b_o    = r_alu.op_b;
    assign alu_op_code_o = r_alu.op_code;
    assign rsp0_valid_o  = r_rsp_valid[0];
    assign rsp1_valid_o  = r_rsp_valid[1];
    assign rsp0_result_o = r_rsp_result[0];
    assign rsp1_result_o = r_rsp_result[1];
    assign rsp0_branch_o = r_rsp_branch[0];
    assign rsp1_branch_o = r_rsp_branch[1];

    // Arbitration FSM: issue operands, capture ALU output, hold response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_alu        <= '0;
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_rsp_branch <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_alu   <= w_grant1 ? w_req1 : w_req0;
                        r_owner <= w_grant1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        r_last_grant <= w_grant1;
`endif
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Operands have been stable for a full cycle; ALU output is valid.
                    r_rsp_result[r_owner] <= alu_result_i;
                    r_rsp_branch[r_owner] <= alu_branch_i;
                    r_rsp_valid[r_owner]  <= 1'b1;
                    r_state               <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_ready[r_owner]) begin
                        r_rsp_valid <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= '0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model. The ALU itself is modelled here.
module tb_alu_arbiter;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_SRA  = 4'd4;
    localparam logic [3:0] OP_BEQ  = 4'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_branch, rsp1_branch;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        alu_branch;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Reference ALU: {branch, result}
    function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return {1'b0, a + b};
            OP_SUB:  return {1'b0, a - b};
            OP_SLT:  return {1'b0, 31'd0, ($signed(a) < $signed(b))};
            OP_SLTU: return {1'b0, 31'd0, (a < b)};
            OP_SRA:  return {1'b0, 32'($signed(a) >>> b[4:0])};
            OP_BEQ:  return {(a == b), a - b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    assign {alu_branch, alu_result} = alu_ref(alu_op, alu_a, alu_b);

    alu_arbiter #(.DATA_W(32), .OPC_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
        .req0_op_a_i(req0_a), .req0_op_b_i(req0_b), .req0_op_code_i(req0_op),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
        .req1_op_a_i(req1_a), .req1_op_b_i(req1_b), .req1_op_code_i(req1_op),
        .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
        .rsp0_result_o(rsp0_result), .rsp0_branch_o(rsp0_branch),
        .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
        .rsp1_result_o(rsp1_result), .rsp1_branch_o(rsp1_branch),
        .alu_op_a_o(alu_a), .alu_op_b_o(alu_b), .alu_op_code_o(alu_op),
        .alu_result_i(alu_result), .alu_branch_i(alu_branch),
        .busy_o(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'h1234; req1_a = 32'h5678; req0_op = OP_ADD; req1_op = OP_SUB;
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            n_cmp++;
            if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
                n_err++;
                $display("FAIL reset_handshake cyc%0d got %b want 00000", i,
                         {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
            end
            n_cmp++;
            if ({alu_a, alu_b, alu_op, rsp0_result, rsp1_result, rsp0_branch, rsp1_branch} !== '0) begin
                n_err++;
                $display("FAIL reset_regs cyc%0d got a=%h b=%h op=%h r0=%h r1=%h want all 0", i,
                         alu_a, alu_b, alu_op, rsp0_result, rsp1_result);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = OP_ADD;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++; $display("FAIL add_ready got %b want 10", {req0_ready, req1_ready});
        end
        tick();   // T+1
        req0_valid = 1'b0; req0_a = 32'hDEAD_BEEF; req0_b = 32'h0;
        #1;
        n_cmp++;
        if ({busy, rsp0_valid, rsp1_valid} !== 3'b100) begin
            n_err++; $display("FAIL add_exec_flags got %b want 100", {busy, rsp0_valid, rsp1_valid});
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_op} !== {32'd5, 32'd7, OP_ADD}) begin
            n_err++; $display("FAIL add_alu_ops got %h/%h/%h want 5/7/0", alu_a, alu_b, alu_op);
        end
        tick();   // T+2
        #1;
        n_cmp++;
        if ({rsp0_valid, rsp1_valid, rsp0_branch, rsp0_result} !== {3'b100, 32'd12}) begin
            n_err++; $display("FAIL add_rsp got v=%b%b br=%b res=%0d want v=10 br=0 res=12",
                              rsp0_valid, rsp1_valid, rsp0_branch, rsp0_result);
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        #1;
        n_cmp++;
        if ({busy, rsp0_valid} !== 2'b00) begin
            n_err++; $display("FAIL add_release got busy=%b v=%b want 0 0", busy, rsp0_valid);
        end
    endtask

    task automatic test_contention();
        int g = 0;
        int cyc = 0;
        logic want;
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd3;  req0_b = 32'd3; req0_op = OP_BEQ;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd4; req1_op = OP_SUB;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        while (g < 6 && cyc < 100) begin
            #1;
            if (req0_ready || req1_ready) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                want = 1'b0;
`else
                want = g[0];
`endif
                n_cmp++;
                if ({req0_ready, req1_ready} !== {~want, want}) begin
                    n_err++; $display("FAIL contention_grant%0d got r0=%b r1=%b want grant %0d",
                                      g, req0_ready, req1_ready, want);
                end
                g++;
            end
            if (rsp0_valid) begin
                n_cmp++;
                if ({rsp0_branch, rsp0_result} !== {1'b1, 32'd0}) begin
                    n_err++; $display("FAIL contention_rsp0 got br=%b res=%h want br=1 res=0", rsp0_branch, rsp0_result);
                end
            end
            if (rsp1_valid) begin
                n_cmp++;
                if ({rsp1_branch, rsp1_result} !== {1'b0, 32'd6}) begin
                    n_err++; $display("FAIL contention_rsp1 got br=%b res=%h want br=0 res=6", rsp1_branch, rsp1_result);
                end
            end
            tick();
            cyc++;
        end
        if (g < 6) begin
            n_cmp++; n_err++;
            $display("FAIL contention_timeout got %0d grants want 6", g);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) tick();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_res;
        logic [31:0] exp0;
        req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_op = OP_SUB;
        exp_res = req1_a - req1_b;
        #1;
        n_cmp++;
        if (req1_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_accept got %b want 1", req1_ready);
        end
        tick();   // T+1
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd23; req0_op = OP_ADD;
        exp0 = 32'd123;
        tick();   // T+2, RESP
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if ({req0_ready, rsp0_valid, rsp1_valid, rsp1_result} !== {3'b001, exp_res}) begin
                n_err++; $display("FAIL bp_hold%0d got r0rdy=%b v=%b%b res=%h want 0 01 %h",
                                  i, req0_ready, rsp0_valid, rsp1_valid, rsp1_result, exp_res);
            end
            tick();
        end
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        #1;
        n_cmp++;
        if ({busy, rsp1_valid, req0_ready} !== 3'b001) begin
            n_err++; $display("FAIL bp_release got busy=%b v1=%b r0rdy=%b want 0 0 1", busy, rsp1_valid, req0_ready);
        end
        tick();   // req0 accepted at previous edge, EXEC
        req0_valid = 1'b0;
        tick();   // RESP
        #1;
        n_cmp++;
        if ({rsp0_valid, rsp0_result, rsp1_result} !== {1'b1, exp0, exp_res}) begin
            n_err++; $display("FAIL bp_followup got v=%b r0=%h r1=%h want 1 %h %h", rsp0_valid, rsp0_result, rsp1_result, exp0, exp_res);
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b;
        logic [31:0] r1_before;
        do_reset();
        r1_before = rsp1_result;
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_op = OP_SLT;
        #1;
        n_cmp++;
        if (req1_ready !== 1'b1) begin
            n_err++; $display("FAIL midrst_accept got %b want 1", req1_ready);
        end
        tick();   // EXEC
        req1_valid = 1'b0;
        rsp1_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp++;
            if ({rsp1_valid, busy, rsp1_result} !== {2'b00, r1_before}) begin
                n_err++; $display("FAIL midrst_quiet%0d got v1=%b busy=%b res=%h want 0 0 %h",
                                  i, rsp1_valid, busy, rsp1_result, r1_before);
            end
            tick();
        end
        rsp1_ready = 1'b0;
        a = $urandom; b = $urandom;
        req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = OP_ADD;
        tick();
        req0_valid = 1'b0;
        tick();
        #1;
        n_cmp++;
        if ({rsp0_valid, rsp1_valid, rsp0_result} !== {2'b10, a + b}) begin
            n_err++; $display("FAIL midrst_next got v=%b%b res=%h want 10 %h", rsp0_valid, rsp1_valid, rsp0_result, a + b);
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
    endtask

    task automatic test_boundary();
        logic [31:0] ta [2];
        logic [31:0] tb [2];
        logic [3:0]  top [2];
        logic [31:0] texp [2];
        ta[0] = 32'h8000_0000; tb[0] = 32'd31;         top[0] = OP_SRA;  texp[0] = 32'hFFFF_FFFF;
        ta[1] = 32'h0;         tb[1] = 32'hFFFF_FFFF;  top[1] = OP_SLTU; texp[1] = 32'd1;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                req0_valid = 1'b1; req0_a = ta[k]; req0_b = tb[k]; req0_op = top[k];
            end else begin
                req1_valid = 1'b1; req1_a = ta[k]; req1_b = tb[k]; req1_op = top[k];
            end
            tick();   // T+1
            req0_valid = 1'b0; req1_valid = 1'b0;
            #1;
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++; $display("FAIL bnd%0d_busy_exec got %b want 1", k, busy);
            end
            tick();   // T+2
            for (int i = 0; i < 2; i++) begin
                #1;
                n_cmp++;
                if ({busy, (k == 0) ? rsp0_valid : rsp1_valid, (k == 0) ? rsp0_result : rsp1_result} !== {2'b11, texp[k]}) begin
                    n_err++; $display("FAIL bnd%0d_rsp got busy=%b res=%h/%h want 1 %h", k, busy, rsp0_result, rsp1_result, texp[k]);
                end
                tick();
            end
            rsp0_ready = 1'b1; rsp1_ready = 1'b1;
            tick();
            rsp0_ready = 1'b0; rsp1_ready = 1'b0;
            #1;
            n_cmp++;
            if (busy !== 1'b0) begin
                n_err++; $display("FAIL bnd%0d_idle got busy=%b want 0", k, busy);
            end
        end
    endtask

    task automatic test_random(input int ncyc);
        // Model: phase 0 = waiting for a request, 1 = operands issued,
        // 2 = response presented to its owner.
        int          ph = 0;
        logic        own = 1'b0;
        logic        last = 1'b1;
        logic [31:0] res [2];
        logic        br [2];
        logic [31:0] ma = '0, mb = '0;
        logic [3:0]  mop = '0;
        logic        e0, e1;
        logic [1:0]  ev;
        logic [31:0] edge_vals [4];
        edge_vals[0] = 32'h0; edge_vals[1] = 32'hFFFF_FFFF; edge_vals[2] = 32'h8000_0000; edge_vals[3] = 32'h7FFF_FFFF;
        res[0] = '0; res[1] = '0; br[0] = 1'b0; br[1] = 1'b0;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_op = 4'($urandom_range(0, 7)); req1_op = 4'($urandom_range(0, 7));
            req0_a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            req0_b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            req1_a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            req1_b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            rsp0_ready = $urandom_range(0, 1);
            rsp1_ready = $urandom_range(0, 1);
            #1;
            e0 = 1'b0; e1 = 1'b0;
            if (ph == 0) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                e0 = req0_valid;
                e1 = req1_valid && !req0_valid;
`else
                if (req0_valid && req1_valid) begin
                    e0 = last; e1 = !last;
                end else begin
                    e0 = req0_valid; e1 = req1_valid;
                end
`endif
            end
            n_cmp++;
            if ({req0_ready, req1_ready} !== {e0, e1}) begin
                n_err++; $display("FAIL rnd_ready c%0d got %b%b want %b%b", c, req0_ready, req1_ready, e0, e1);
            end
            n_cmp++;
            if (busy !== (ph != 0)) begin
                n_err++; $display("FAIL rnd_busy c%0d got %b want %b", c, busy, ph != 0);
            end
            ev = (ph == 2) ? (own ? 2'b01 : 2'b10) : 2'b00;
            n_cmp++;
            if ({rsp0_valid, rsp1_valid} !== ev) begin
                n_err++; $display("FAIL rnd_rspvalid c%0d got %b%b want %b", c, rsp0_valid, rsp1_valid, ev);
            end
            n_cmp++;
            if ({rsp0_branch, rsp0_result, rsp1_branch, rsp1_result} !== {br[0], res[0], br[1], res[1]}) begin
                n_err++; $display("FAIL rnd_rspdata c%0d got %b/%h %b/%h want %b/%h %b/%h", c,
                                  rsp0_branch, rsp0_result, rsp1_branch, rsp1_result, br[0], res[0], br[1], res[1]);
            end
            n_cmp++;
            if ({alu_a, alu_b, alu_op} !== {ma, mb, mop}) begin
                n_err++; $display("FAIL rnd_aluops c%0d got %h/%h/%h want %h/%h/%h", c, alu_a, alu_b, alu_op, ma, mb, mop);
            end
            case (ph)
                0: if (e0 || e1) begin
                    own = e1; last = e1;
                    ma  = e1 ? req1_a : req0_a;
                    mb  = e1 ? req1_b : req0_b;
                    mop = e1 ? req1_op : req0_op;
                    ph  = 1;
                end
                1: begin
                    {br[own], res[own]} = alu_ref(mop, ma, mb);
                    ph = 2;
                end
                default: if ((own ? rsp1_ready : rsp0_ready)) ph = 0;
            endcase
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (4) tick();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_boundary();
        test_random(400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
